// File: rtl/scan_loader.sv
// scan_loader: serial-scan initiator that shifts host bytes into a pattern buffer chain while reading back its old contents
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, addr           begin a transfer to buffer addr (accepted only when idle)
//   in_data/valid/ready   host byte stream to shift in, MSB first
//   out_data, out_valid   byte captured from sout, one-cycle pulse, no backpressure
//   busy, done            transfer in progress / one-cycle end-of-transfer pulse
//   sclk, sin, ssel,
//   saddr, sout           scan pins of the buffer bank
module scan_loader #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              addr,
    input  logic [buffer_width-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [buffer_width-1:0] out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    sin,
    output logic                    ssel,
    output logic [2:0]              saddr,
    input  logic                    sout
);
    localparam int cw = $clog2(buffer_size + 1);
    localparam int bw = $clog2(buffer_width);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, DONE} state_t;

    state_t                  state, state_d;
    logic [buffer_width-1:0] shreg, cap;
    logic [bw-1:0]           bit_cnt;
    logic [cw-1:0]           byte_cnt;
    logic                    phase;
    logic                    byte_end;

    // phase 1 of the last bit closes the byte
    assign byte_end = state == SHIFT && phase && bit_cnt == bw'(buffer_width - 1);

    always_comb begin
        state_d  = state;
        busy     = state != IDLE;
        ssel     = state == SETUP || state == LOAD || state == SHIFT;
        in_ready = state == LOAD;
        sclk     = state == SHIFT && phase;
        sin      = state == SHIFT && shreg[buffer_width-1];
        done     = state == DONE;
        case (state)
            IDLE:    state_d = start ? SETUP : IDLE;
            SETUP:   state_d = LOAD;
            LOAD:    state_d = in_valid ? SHIFT : LOAD;
            SHIFT:   state_d = !byte_end ? SHIFT : byte_cnt == cw'(buffer_size - 1) ? DONE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            saddr     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            shreg     <= '0;
            cap       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_d;
            out_valid <= byte_end;
            if (state == IDLE && start) begin
                saddr    <= addr;
                byte_cnt <= '0;
            end
            if (state == LOAD && in_valid) begin
                shreg   <= in_data;
                bit_cnt <= '0;
                phase   <= 1'b0;
            end
            if (state == SHIFT) begin
                phase <= ~phase;
                // sout is sampled as phase 0 ends, just before the chain advances on the sclk rise
                if (!phase)
                    cap <= {cap[buffer_width-2:0], sout};
                else begin
                    shreg   <= {shreg[buffer_width-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (byte_end) begin
                out_data <= cap;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_scan_loader.sv
module tb_scan_loader;
    logic       clk = 0, reset = 1, start = 0, in_valid = 0;
    logic [2:0] addr = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, out_valid, busy, done, sclk, sin, ssel, sout;
    logic [7:0] out_data;
    logic [2:0] saddr;

    scan_loader dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .sclk(sclk), .sin(sin), .ssel(ssel), .saddr(saddr), .sout(sout)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, cyc = 0, rises = 0, done_n = 0, done_cyc = 0, viol = 0, timeouts = 0;
    int r0, d0, t0, sin_err, rb_err, ov_n;
    logic       sin_q[$];
    logic [7:0] ov_q[$];
    logic [175:0] chains [8] = '{default: '0};
    logic [175:0] old, exp_chain;
    logic [7:0] pat [22];

    assign sout = ssel ? chains[saddr][175] : 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge sclk) begin
        rises++;
        sin_q.push_back(sin);
        if (ssel) chains[saddr] <= {chains[saddr][174:0], sin};
    end

    always @(negedge clk) begin
        if (out_valid) ov_q.push_back(out_data);
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if ((in_ready && (sclk || !ssel)) || (!ssel && (sclk || sin)) || (!busy && (ssel || in_ready)))
            viol++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int g);
        int k = 0;
        if (g > 0) begin
            in_valid = 0;
            @(negedge clk);
            while (!in_ready && k < 100) begin @(negedge clk); k++; end
            repeat (g) @(posedge clk);
            #1;
        end
        in_valid = 1;
        in_data  = b;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        if (!in_ready) timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] a, input int gmax);
        int k = 0;
        logic [7:0] p;
        old = chains[a];
        r0  = rises;
        d0  = done_n;
        sin_q.delete();
        ov_q.delete();
        @(posedge clk); #1;
        start = 1;
        addr  = a;
        t0    = cyc;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 22; i++) send_byte(pat[i], gmax > 0 ? int'($urandom_range(gmax, 0)) : 0);
        in_valid = 0;
        while (done_n == d0 && k < 100) begin @(negedge clk); k++; end
        if (done_n == d0) timeouts++;
        sin_err = 0;
        for (int i = 0; i < 176; i++) begin
            p = pat[i / 8];
            if (i >= sin_q.size() || sin_q[i] !== p[7 - i % 8]) sin_err++;
        end
        rb_err = 0;
        for (int i = 0; i < 22; i++)
            if (i >= ov_q.size() || ov_q[i] !== old[175 - 8 * i -: 8]) rb_err++;
        for (int i = 0; i < 22; i++) exp_chain[175 - 8 * i -: 8] = pat[i];
        ov_n = ov_q.size();
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        r0 = rises;
        repeat (10) begin
            @(negedge clk);
            if ({in_ready, out_valid, busy, done, sclk, sin, ssel} !== 7'd0) bad++;
        end
        total++; if (bad != 0) $display("FAIL reset_idle_outputs nonzero_cycles=%0d want 0", bad); else passed++;
        total++; if (rises != r0) $display("FAIL reset_sclk_rises got %0d want 0", rises - r0); else passed++;
        total++; if ({saddr, out_data} !== 11'd0) $display("FAIL reset_saddr_out_data got %h/%h want 0/00", saddr, out_data); else passed++;
    endtask

    task automatic test_load();
        for (int i = 0; i < 22; i++) pat[i] = 8'(i);
        run(5, 0);
        total++; if (timeouts != 0) $display("FAIL load_timeout got %0d want 0", timeouts); else passed++;
        total++; if (saddr !== 3'd5) $display("FAIL load_saddr got %0d want 5", saddr); else passed++;
        total++; if (rises - r0 != 176) $display("FAIL load_sclk_rises got %0d want 176", rises - r0); else passed++;
        total++; if (sin_err != 0) $display("FAIL load_sin_sequence errors=%0d want 0", sin_err); else passed++;
        total++; if (done_cyc - t0 != 376) $display("FAIL load_duration got %0d want 376", done_cyc - t0); else passed++;
        total++; if (chains[5] !== exp_chain) $display("FAIL load_chain got %h want %h", chains[5], exp_chain); else passed++;
        total++; if (rb_err != 0) $display("FAIL load_readback_zero errors=%0d want 0", rb_err); else passed++;
        total++; if (done_n - d0 != 1) $display("FAIL load_done_pulses got %0d want 1", done_n - d0); else passed++;
    endtask

    task automatic test_readback();
        for (int i = 0; i < 22; i++) pat[i] = 8'hFF;
        run(5, 0);
        total++; if (ov_n != 22) $display("FAIL readback_pulses got %0d want 22", ov_n); else passed++;
        total++; if (rb_err != 0) $display("FAIL readback_data errors=%0d want 0", rb_err); else passed++;
        total++; if (ov_q.size() > 21 && ov_q[21] !== 8'h15) $display("FAIL readback_last got %h want 15", ov_q[21]); else passed++;
        total++; if (chains[5] !== {176{1'b1}}) $display("FAIL readback_chain_ones got %h want all ones", chains[5]); else passed++;
        total++; if (done_cyc - t0 != 376) $display("FAIL readback_duration got %0d want 376", done_cyc - t0); else passed++;
    endtask

    task automatic test_gaps();
        int v0 = viol;
        for (int i = 0; i < 22; i++) pat[i] = 8'(i);
        run(5, 5);
        total++; if (rises - r0 != 176) $display("FAIL gaps_sclk_rises got %0d want 176", rises - r0); else passed++;
        total++; if (sin_err != 0) $display("FAIL gaps_sin_sequence errors=%0d want 0", sin_err); else passed++;
        total++; if (rb_err != 0) $display("FAIL gaps_readback_ones errors=%0d want 0", rb_err); else passed++;
        total++; if (chains[5] !== exp_chain) $display("FAIL gaps_chain got %h want %h", chains[5], exp_chain); else passed++;
        total++; if (viol != v0) $display("FAIL gaps_pin_rules violations=%0d want 0", viol - v0); else passed++;
        total++; if (done_cyc - t0 <= 376) $display("FAIL gaps_stall_visible duration=%0d want >376", done_cyc - t0); else passed++;
    endtask

    task automatic test_ignored();
        int bad = 0, r = rises, dn;
        repeat (3) begin
            @(posedge clk); #1;
            in_valid = 1;
            in_data  = 8'hEE;
            @(negedge clk);
            if (busy !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        in_valid = 0;
        total++; if (bad != 0) $display("FAIL ignored_in_valid_idle busy_cycles=%0d want 0", bad); else passed++;
        total++; if (rises != r) $display("FAIL ignored_idle_rises got %0d want 0", rises - r); else passed++;
        for (int i = 0; i < 22; i++) pat[i] = 8'h30 + 8'(i);
        fork
            run(5, 0);
            begin
                repeat (40) @(posedge clk);
                #2 start = 1; addr = 2;
                @(posedge clk);
                #2 start = 0;
            end
        join
        total++; if (saddr !== 3'd5) $display("FAIL ignored_saddr got %0d want 5", saddr); else passed++;
        total++; if (rises - r0 != 176) $display("FAIL ignored_sclk_rises got %0d want 176", rises - r0); else passed++;
        total++; if (rb_err != 0) $display("FAIL ignored_readback errors=%0d want 0", rb_err); else passed++;
        dn = done_n;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        total++; if (bad != 0 || done_n != dn) $display("FAIL ignored_no_restart busy_cycles=%0d extra_done=%0d want 0/0", bad, done_n - dn); else passed++;
    endtask

    task automatic test_reset_mid();
        int n0, dn;
        @(posedge clk); #1;
        start = 1;
        addr  = 3;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 0);
        in_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        n0 = ov_q.size();
        dn = done_n;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        total++; if ({ssel, sclk, sin, busy} !== 4'd0) $display("FAIL reset_mid_pins got %b want 0000", {ssel, sclk, sin, busy}); else passed++;
        repeat (20) @(negedge clk);
        total++; if (ov_q.size() != n0 || done_n != dn) $display("FAIL reset_mid_no_pulses out_valid=%0d done=%0d want 0/0", ov_q.size() - n0, done_n - dn); else passed++;
        for (int i = 0; i < 22; i++) pat[i] = 8'h5A ^ 8'(i);
        run(3, 0);
        total++; if (rises - r0 != 176 || sin_err != 0) $display("FAIL reset_mid_reload rises=%0d sin_errors=%0d want 176/0", rises - r0, sin_err); else passed++;
        total++; if (chains[3] !== exp_chain) $display("FAIL reset_mid_chain got %h want %h", chains[3], exp_chain); else passed++;
        total++; if (ov_n != 22 || done_n - d0 != 1) $display("FAIL reset_mid_pulses out_valid=%0d done=%0d want 22/1", ov_n, done_n - d0); else passed++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_readback();
        test_gaps();
        test_ignored();
        test_reset_mid();
        total++; if (viol != 0) $display("FAIL pin_rules violations=%0d want 0", viol); else passed++;
        total++; if (timeouts != 0) $display("FAIL handshake_timeouts got %0d want 0", timeouts); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/scan_loader.md
# scan_loader

Serial-scan initiator for the pattern-buffer bank. Accepts a target buffer address and a stream of `buffer_size` bytes from the host side, then drives `sclk`/`sin`/`ssel`/`saddr` to shift the bytes into the selected buffer's scan chain. It simultaneously captures the chain's previous contents from `sout` and returns them byte by byte for readback. It sits between the host/config logic and the `sclk`, `sin`, `sout`, `ssel` and `saddr` pins of the buffer bank.

## Interface
- `buffer_size`, 22, bytes per pattern buffer (chain length = `buffer_size*buffer_width` bits)
- `buffer_width`, 8, bits per byte
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a transfer; sampled only in IDLE
- `addr`  in  3  target buffer, latched on accepted `start`
- `in_data`  in  `buffer_width`  byte to shift in
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `out_data`  out  `buffer_width`  byte captured from `sout`
- `out_valid`  out  1  one-cycle pulse, `out_data` valid; no backpressure
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at end of transfer
- `sclk`  out  1  scan clock to buffer bank
- `sin`  out  1  scan data to buffer bank
- `ssel`  out  1  scan select to buffer bank
- `saddr`  out  3  scan buffer address
- `sout`  in  1  scan data from buffer bank (high-Z when `ssel` is low)

## Operation
- States: IDLE, SETUP, LOAD, SHIFT, DONE.
- **IDLE**: `start` latches `addr` into `saddr`, clears the byte counter, and moves to SETUP. `in_valid` is ignored in IDLE.
- **SETUP** (1 cycle): `ssel`=1, `sclk`=0. Moves to LOAD.
- **LOAD**: `in_ready`=1. When `in_valid` is high, the block latches `in_data` into the shift register, clears the bit counter and moves to SHIFT. Otherwise it waits with `ssel` held high and `sclk`=0.
- **SHIFT**: 2 cycles per bit, 8 bits.
  - Phase 0: `sclk`=0, `sin` = current MSB.
  - Phase 1: `sclk`=1, `sin` held.
  - `sout` is sampled on the clk edge that ends phase 0 and shifted into the capture register LSB-first-in (the first sampled bit becomes the MSB).
  - After phase 1 of bit 7: `out_data` = capture register, `out_valid`=1 for one cycle, byte counter increments.
  - Next state is LOAD, or DONE if the byte counter reaches `buffer_size`.
- **DONE** (1 cycle): `ssel`=0, `sclk`=0, `done`=1. Moves to IDLE.
- Bytes are sent in host order, each byte MSB first.
- `sin`=0 and `sclk`=0 in every state except SHIFT.
- `saddr` is stable from SETUP through DONE and holds its last value in IDLE.
- `start` while `busy` is ignored.
- Counters: bit counter 3 bits, byte counter `$clog2(buffer_size+1)` bits; no wrap within a transfer.

## Timing
- Reset values: state IDLE; `sclk`, `sin`, `ssel`, `in_ready`, `out_valid`, `done`, `busy` = 0; `saddr` = 0; `out_data` = 0.
- `start` at cycle N:
  - `busy`, `ssel` high at N+1 (SETUP).
  - `in_ready` high at N+2.
- A byte accepted at cycle M:
  - SHIFT occupies M+1..M+16.
  - First `sclk` rise at M+2.
  - `out_valid` at M+17, concurrent with `in_ready` (LOAD) or `done` (DONE).
- With `in_valid` held high, a full transfer is 1 + 17×`buffer_size` + 1 cycles (376 at defaults).
- `sclk` period is 2 clk cycles with 50% duty. `sin` is stable for one full clk cycle before and after each `sclk` rise.
- `reset` mid-transfer: next cycle `ssel`=`sclk`=`sin`=0, state IDLE, no `done`, no `out_valid`. The target buffer contents are undefined and must be reloaded.
- `in_valid` deasserted in LOAD: stall of any length with chain frozen (`sclk` low).

## Test plan
- Reset, then idle 10 cycles → all outputs 0, `sclk` never toggles.
- `start` with `addr`=5 and bytes 0x00..0x15 streamed with `in_valid` held → `saddr`=5, 176 `sclk` rises, `sin` sequence matches bytes MSB-first, `done` at cycle 376 after `start`; behavioural chain model holds 0x00..0x15.
- Second transfer to `addr`=5 with 0xFF×22 → `out_data` sequence 0x00..0x15 with 22 `out_valid` pulses; chain then all ones.
- Random `in_valid` gaps of 0–5 cycles → `sclk` low during every gap, data identical to the no-gap run, `in_ready` only in LOAD.
- Assert `reset` during bit 3 of byte 7 → next cycle `ssel`/`sclk`/`sin` = 0, `busy`=0; a following full transfer completes correctly.
- `start` pulsed while `busy`, and `in_valid` pulsed in IDLE → both ignored, no extra shifts, `addr` unchanged.
